i2c_multibus_monitor: RTL

- Passive RTL I2C bus monitor observing NUM_BUSES independent SCL/SDA pairs, for example the multi-bus outputs of the I2CMB DUT.
- For each bus it synchronises and deglitches both lines, then detects START, repeated START, STOP and 8-bit data bytes with their ACK bit.
- Decoded events are merged round-robin into one shared record FIFO with a valid/ready output. This gives environments and emulation a hardware-side transaction stream.

---
 rtl/i2c_mon_pkg.sv | 17 +
 rtl/i2c_mon_filter.sv | 40 ++++
 rtl/i2c_multibus_monitor.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/i2c_mon_pkg.sv
// Types shared by the I2C multi-bus monitor: record kinds, the record layout
// and the per-bus decoder state.
package i2c_mon_pkg;
  localparam int MON_MAX_BUSES = 16;
  localparam int MON_BUS_W     = 4;

  typedef enum logic [1:0] {MON_START, MON_RSTART, MON_STOP, MON_BYTE} mon_kind_t;

  typedef struct packed {
    logic [MON_BUS_W-1:0] bus;
    mon_kind_t            kind;
    logic [7:0]           data;
    logic                 ack;
  } mon_rec_t;

  typedef enum logic {ST_IDLE, ST_ACTIVE} mon_state_t;
endpackage

// File: rtl/i2c_mon_filter.sv
// Two-flop synchroniser plus FILTER_LEN-sample agreement filter for one
// open-drain line; the output idles high.
module i2c_mon_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_i,
  output logic out_o
);
  logic       sync1_q, sync2_q;
  logic       filt_q, filt_d;
  logic [3:0] cnt_q, cnt_d;

  // cnt_q counts consecutive synchronised samples that disagree with the output
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == 4'(FILTER_LEN - 1)) filt_d = sync2_q;
      else                             cnt_d  = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= in_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_o = filt_q;
endmodule

// File: rtl/i2c_multibus_monitor.sv
// Passive monitor for NUM_BUSES I2C buses: per-bus START/STOP/byte decode,
// one pending slot per bus, round-robin merge into a shared record FIFO.
//   state     | meaning
//   ST_IDLE   | no transaction open; SCL edges and STOP ignored
//   ST_ACTIVE | inside a transaction; bit_q counts 0..8 within the current byte
module i2c_multibus_monitor
  import i2c_mon_pkg::*;
#(
  parameter int  NUM_BUSES  = 4,
  parameter int  FILTER_LEN = 3,
  parameter int  FIFO_DEPTH = 16,
  parameter int  CNT_W      = 16,
  localparam int BUS_W      = (NUM_BUSES > 1) ? $clog2(NUM_BUSES) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_BUSES-1:0] scl_i,
  input  logic [NUM_BUSES-1:0] sda_i,
  input  logic                 clear_i,
  output logic                 rec_valid_o,
  input  logic                 rec_ready_i,
  output logic [BUS_W-1:0]     rec_bus_o,
  output logic [1:0]           rec_kind_o,
  output logic [7:0]           rec_data_o,
  output logic                 rec_ack_o,
  output logic                 overflow_o,
  output logic [CNT_W-1:0]     drop_count_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [NUM_BUSES-1:0] scl_f, sda_f, scl_p_q, sda_p_q;
  mon_state_t           state_q [NUM_BUSES];
  mon_state_t           state_d [NUM_BUSES];
  logic [3:0]           bit_q   [NUM_BUSES];
  logic [3:0]           bit_d   [NUM_BUSES];
  logic [7:0]           shift_q [NUM_BUSES];
  logic [7:0]           shift_d [NUM_BUSES];
  mon_rec_t             slot_q  [NUM_BUSES];
  mon_rec_t             slot_d  [NUM_BUSES];
  logic [NUM_BUSES-1:0] slot_full_q, slot_full_d;
  logic [BUS_W-1:0]     rr_q, rr_d, grant_idx;
  logic                 push, pop;
  mon_rec_t             mem_q [FIFO_DEPTH];
  mon_rec_t             head;
  logic [PTR_W-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [PTR_W:0]       count_q, count_d;
  logic [4:0]           ndrop;
  logic [CNT_W+4:0]     drop_sum;
  logic                 overflow_q, overflow_d;
  logic [CNT_W-1:0]     drop_q, drop_d;

  for (genvar g = 0; g < NUM_BUSES; g++) begin : g_bus
    i2c_mon_filter #(.FILTER_LEN(FILTER_LEN)) u_scl (
      .clk_i(clk_i), .rst_i(rst_i), .in_i(scl_i[g]), .out_o(scl_f[g]));
    i2c_mon_filter #(.FILTER_LEN(FILTER_LEN)) u_sda (
      .clk_i(clk_i), .rst_i(rst_i), .in_i(sda_i[g]), .out_o(sda_f[g]));
  end

  // rr_q holds the first index to search, i.e. one past the last grant
  always_comb begin
    int idx;
    idx       = 0;
    pop       = (count_q != '0) && rec_ready_i;
    push      = 1'b0;
    grant_idx = '0;
    if ((count_q != (PTR_W+1)'(FIFO_DEPTH)) || pop) begin
      for (int i = 0; i < NUM_BUSES; i++) begin
        idx = (int'(rr_q) + i) % NUM_BUSES;
        if (!push && slot_full_q[BUS_W'(idx)]) begin
          push      = 1'b1;
          grant_idx = BUS_W'(idx);
        end
      end
    end
    rr_d    = push ? BUS_W'((int'(grant_idx) + 1) % NUM_BUSES) : rr_q;
    wr_d    = push ? wr_q + 1'b1 : wr_q;
    rd_d    = pop ? rd_q + 1'b1 : rd_q;
    count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  end

  always_comb begin
    mon_rec_t ev_rec;
    logic     ev, scl_rise, start_c, stop_c;
    ev_rec = '0;
    ev     = 1'b0;
    ndrop  = '0;
    for (int b = 0; b < NUM_BUSES; b++) begin
      state_d[b]     = state_q[b];
      bit_d[b]       = bit_q[b];
      shift_d[b]     = shift_q[b];
      slot_d[b]      = slot_q[b];
      slot_full_d[b] = slot_full_q[b] && !(push && int'(grant_idx) == b);
      scl_rise = scl_f[b] & ~scl_p_q[b];
      start_c  = scl_f[b] & scl_p_q[b] & sda_p_q[b] & ~sda_f[b];
      stop_c   = scl_f[b] & scl_p_q[b] & ~sda_p_q[b] & sda_f[b];
      ev       = 1'b0;
      ev_rec   = '{bus: MON_BUS_W'(b), kind: MON_START, data: 8'h00, ack: 1'b0};
      if (start_c) begin
        ev          = 1'b1;
        ev_rec.kind = (state_q[b] == ST_ACTIVE) ? MON_RSTART : MON_START;
        state_d[b]  = ST_ACTIVE;
        bit_d[b]    = '0;
        shift_d[b]  = '0;
      end else if (stop_c && state_q[b] == ST_ACTIVE) begin
        ev          = 1'b1;
        ev_rec.kind = MON_STOP;
        state_d[b]  = ST_IDLE;
        bit_d[b]    = '0;
      end else if (scl_rise && state_q[b] == ST_ACTIVE) begin
        if (bit_q[b] == 4'd8) begin
          ev          = 1'b1;
          ev_rec.kind = MON_BYTE;
          ev_rec.data = shift_q[b];
          ev_rec.ack  = sda_f[b];
          bit_d[b]    = '0;
        end else begin
          shift_d[b] = {shift_q[b][6:0], sda_f[b]};
          bit_d[b]   = bit_q[b] + 4'd1;
        end
      end
      if (ev) begin
        if (!slot_full_d[b]) begin
          slot_full_d[b] = 1'b1;
          slot_d[b]      = ev_rec;
        end else begin
          ndrop = ndrop + 5'd1;
        end
      end
    end
  end

  always_comb begin
    drop_sum   = {5'b0, (clear_i ? {CNT_W{1'b0}} : drop_q)} + {{CNT_W{1'b0}}, ndrop};
    drop_d     = (drop_sum > {5'b0, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
    overflow_d = (overflow_q && !clear_i) || (ndrop != '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_p_q     <= '1;
      sda_p_q     <= '1;
      slot_full_q <= '0;
      for (int b = 0; b < NUM_BUSES; b++) begin
        state_q[b] <= ST_IDLE;
        bit_q[b]   <= '0;
        shift_q[b] <= '0;
        slot_q[b]  <= '0;
      end
      rr_q       <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      scl_p_q     <= scl_f;
      sda_p_q     <= sda_f;
      slot_full_q <= slot_full_d;
      state_q     <= state_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      slot_q      <= slot_d;
      rr_q        <= rr_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      drop_q      <= drop_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= slot_q[grant_idx];
  end

  // Record fields are forced to zero while the FIFO is empty so stale entries never show
  assign head         = mem_q[rd_q];
  assign rec_valid_o  = (count_q != '0);
  assign rec_bus_o    = rec_valid_o ? BUS_W'(head.bus) : '0;
  assign rec_kind_o   = rec_valid_o ? 2'(head.kind) : 2'b00;
  assign rec_data_o   = rec_valid_o ? head.data : 8'h00;
  assign rec_ack_o    = rec_valid_o & head.ack;
  assign overflow_o   = overflow_q;
  assign drop_count_o = drop_q;
endmodule
